// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer, round-robin (MODE=0) or explicit select (MODE=1).
// Optional packet lock on in_last/out_last when STREAM_MUX_LOCK_EN is defined.
module stream_mux_rr #(
   parameter int WIDTH    = 8,
   parameter int CHANNELS = 4,
   parameter int MODE     = 0,
   localparam int SELW    = $clog2(CHANNELS)
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [CHANNELS*WIDTH-1:0] in_data,
   input  logic [CHANNELS-1:0]       in_valid,
   output logic [CHANNELS-1:0]       in_ready,
`ifdef STREAM_MUX_LOCK_EN
   input  logic [CHANNELS-1:0]       in_last,
   output logic                      out_last,
`endif
   input  logic [SELW-1:0]           sel,
   output logic [WIDTH-1:0]          out_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [SELW-1:0]           out_sel
);

   logic [WIDTH-1:0]    out_data_q, out_data_d;
   logic                out_valid_q, out_valid_d;
   logic [SELW-1:0]     out_sel_q, out_sel_d;
   logic [SELW-1:0]     ptr_q, ptr_d;
   logic                locked;

   logic                load;
   logic                accept;
   logic                gsel;
   logic                gvalid;
   logic [SELW-1:0]     gidx;
   logic [SELW-1:0]     gnext;
   logic [CHANNELS-1:0] grant;
   logic [WIDTH-1:0]    gdata;

`ifdef STREAM_MUX_LOCK_EN
   logic lock_q, lock_d;
   logic out_last_q, out_last_d;
   assign locked   = lock_q;
   assign out_last = out_last_q;
`else
   assign locked   = 1'b0;
`endif

   // While locked the grant stays on the channel that supplied the last beat.
   always_comb begin
      int c;
      logic [SELW-1:0] cidx;
      c    = 0;
      cidx = '0;
      gidx = '0;
      gsel = 1'b0;
      if (locked) begin
         gidx = out_sel_q;
         gsel = 1'b1;
      end else if (MODE == 0) begin
         for (int k = 0; k < CHANNELS; k++) begin
            c = int'(ptr_q) + k;
            if (c >= CHANNELS) c = c - CHANNELS;
            cidx = SELW'(c);
            if (!gsel && in_valid[cidx]) begin
               gidx = cidx;
               gsel = 1'b1;
            end
         end
      end else if (int'(sel) < CHANNELS) begin
         gidx = sel;
         gsel = 1'b1;
      end
   end

   always_comb begin
      gdata = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (SELW'(i) == gidx) gdata = in_data[i*WIDTH +: WIDTH];
      end
   end

   assign load     = !out_valid_q || out_ready;
   assign grant    = gsel ? (CHANNELS'(1) << gidx) : '0;
   assign gvalid   = gsel && in_valid[gidx];
   assign accept   = load && gvalid;
   assign in_ready = grant & {CHANNELS{load && rst_n}};
   assign gnext    = (gidx == SELW'(CHANNELS - 1)) ? '0 : gidx + 1'b1;

   always_comb begin
      out_valid_d = out_valid_q;
      out_data_d  = out_data_q;
      out_sel_d   = out_sel_q;
      ptr_d       = ptr_q;
`ifdef STREAM_MUX_LOCK_EN
      lock_d      = lock_q;
      out_last_d  = out_last_q;
`endif
      if (accept) begin
         out_valid_d = 1'b1;
         out_data_d  = gdata;
         out_sel_d   = gidx;
`ifdef STREAM_MUX_LOCK_EN
         lock_d      = !in_last[gidx];
         out_last_d  = in_last[gidx];
         if (MODE == 0 && in_last[gidx]) ptr_d = gnext;
`else
         if (MODE == 0) ptr_d = gnext;
`endif
      end else if (load) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_sel_q   <= '0;
         ptr_q       <= '0;
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= 1'b0;
         out_last_q  <= 1'b0;
`endif
      end else begin
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         out_sel_q   <= out_sel_d;
         ptr_q       <= ptr_d;
`ifdef STREAM_MUX_LOCK_EN
         lock_q      <= lock_d;
         out_last_q  <= out_last_d;
`endif
      end
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign out_sel   = out_sel_q;

endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel round-robin instance and a 5-channel select instance
// checked every cycle against a transfer-level reference model.
module tb_stream_mux_rr;

`ifdef STREAM_MUX_LOCK_EN
   localparam bit LOCK = 1'b1;
`else
   localparam bit LOCK = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [39:0] in_data;
   logic [4:0]  in_valid;
   logic [4:0]  in_last;
   logic [2:0]  sel;
   logic        out_ready;

   logic [3:0]  rdy0;
   logic [7:0]  od0;
   logic        ov0;
   logic [1:0]  os0;
   logic        ol0;
   logic [4:0]  rdy1;
   logic [7:0]  od1;
   logic        ov1;
   logic [2:0]  os1;
   logic        ol1;

   int total = 0;
   int bad   = 0;

   // Reference model state, index 0 = round-robin instance, 1 = select instance.
   int          nch[2] = '{4, 5};
   int          mptr[2];
   int          mlock[2];
   int          ms[2];
   bit          mv[2];
   bit          ml[2];
   logic [7:0]  md[2];

   always #5 clk = ~clk;

   stream_mux_rr #(.WIDTH(8), .CHANNELS(4), .MODE(0)) dut0 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data[31:0]), .in_valid(in_valid[3:0]), .in_ready(rdy0),
`ifdef STREAM_MUX_LOCK_EN
      .in_last(in_last[3:0]), .out_last(ol0),
`endif
      .sel(sel[1:0]), .out_data(od0), .out_valid(ov0), .out_ready(out_ready), .out_sel(os0)
   );

   stream_mux_rr #(.WIDTH(8), .CHANNELS(5), .MODE(1)) dut1 (
      .clk(clk), .rst_n(rst_n),
      .in_data(in_data), .in_valid(in_valid), .in_ready(rdy1),
`ifdef STREAM_MUX_LOCK_EN
      .in_last(in_last), .out_last(ol1),
`endif
      .sel(sel), .out_data(od1), .out_valid(ov1), .out_ready(out_ready), .out_sel(os1)
   );

`ifndef STREAM_MUX_LOCK_EN
   assign ol0 = 1'b0;
   assign ol1 = 1'b0;
`endif

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int m = 0; m < 2; m++) begin
         mptr[m] = 0; mlock[m] = -1; ms[m] = 0; mv[m] = 0; ml[m] = 0; md[m] = 8'h00;
      end
   endtask

   function automatic int grant_of(input int m);
      if (mlock[m] >= 0) return mlock[m];
      if (m == 0) begin
         for (int k = 0; k < nch[m]; k++) begin
            if (in_valid[(mptr[m] + k) % nch[m]]) return (mptr[m] + k) % nch[m];
         end
         return -1;
      end
      if (int'(sel) < nch[m]) return int'(sel);
      return -1;
   endfunction

   task automatic cycle();
      int   gg[2];
      bit   ld[2];
      bit   lst;
      logic [4:0] er;
      #1;
      for (int m = 0; m < 2; m++) begin
         gg[m] = grant_of(m);
         ld[m] = !mv[m] || out_ready;
         er = (gg[m] >= 0 && ld[m] && rst_n) ? (5'd1 << gg[m]) : 5'd0;
         if (m == 0) chk("in_ready0", {36'd0, rdy0}, {35'd0, er});
         else        chk("in_ready1", {35'd0, rdy1}, {35'd0, er});
      end
      @(posedge clk);
      for (int m = 0; m < 2; m++) begin
         if (ld[m] && gg[m] >= 0 && in_valid[gg[m]]) begin
            lst   = LOCK ? in_last[gg[m]] : 1'b1;
            md[m] = in_data[gg[m]*8 +: 8];
            ms[m] = gg[m];
            mv[m] = 1'b1;
            ml[m] = LOCK ? lst : 1'b0;
            mlock[m] = lst ? -1 : gg[m];
            if (m == 0 && lst) mptr[m] = (gg[m] + 1) % nch[m];
         end else if (ld[m]) begin
            mv[m] = 1'b0;
         end
      end
      #1;
      chk("out_valid0", {39'd0, ov0}, {39'd0, mv[0]});
      chk("out_data0",  {32'd0, od0}, {32'd0, md[0]});
      chk("out_sel0",   {38'd0, os0}, 40'(ms[0]));
      chk("out_last0",  {39'd0, ol0}, {39'd0, ml[0]});
      chk("out_valid1", {39'd0, ov1}, {39'd0, mv[1]});
      chk("out_data1",  {32'd0, od1}, {32'd0, md[1]});
      chk("out_sel1",   {37'd0, os1}, 40'(ms[1]));
      chk("out_last1",  {39'd0, ol1}, {39'd0, ml[1]});
   endtask

   task automatic beat0(input int s, input int d);
      cycle();
      chk("dir_valid0", {39'd0, ov0}, 40'd1);
      chk("dir_sel0",   {38'd0, os0}, 40'(s));
      chk("dir_data0",  {32'd0, od0}, 40'(d));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 3; i++) begin
         @(posedge clk);
         #1;
         chk("rst_valid0", {39'd0, ov0}, 40'd0);
         chk("rst_data0",  {32'd0, od0}, 40'd0);
         chk("rst_sel0",   {38'd0, os0}, 40'd0);
         chk("rst_ready0", {36'd0, rdy0}, 40'd0);
         chk("rst_ready1", {35'd0, rdy1}, 40'd0);
         chk("rst_valid1", {39'd0, ov1}, 40'd0);
      end
      rst_n = 1'b1;
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      in_data   = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
      in_valid  = 5'b11111;
      in_last   = 5'b11111;
      sel       = 3'd2;
      out_ready = 1'b1;
      model_reset();
      do_reset();

      // Round-robin fairness from reset, then up to holding 0x12
      beat0(0, 8'h10); beat0(1, 8'h11); beat0(2, 8'h12); beat0(3, 8'h13); beat0(0, 8'h10);
      beat0(1, 8'h11); beat0(2, 8'h12);

      // Backpressure holds 0x12 with no ready anywhere, then 0x13 without a bubble
      out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         cycle();
         chk("bp_data0",  {32'd0, od0}, 40'h12);
         chk("bp_ready0", {36'd0, rdy0}, 40'd0);
      end
      out_ready = 1'b1;
      beat0(3, 8'h13);

      // Sparse valid with ptr at 2
      beat0(0, 8'h10); beat0(1, 8'h11);
      in_valid = 5'b01010;
      beat0(3, 8'h13); beat0(1, 8'h11); beat0(3, 8'h13);

      // Explicit select instance
      in_valid = 5'b11111;
      sel = 3'd2;
      cycle();
      chk("sel2_sel1",  {37'd0, os1}, 40'd2);
      chk("sel2_data1", {32'd0, od1}, 40'h12);
      sel = 3'd4;
      cycle();
      chk("sel4_data1", {32'd0, od1}, 40'h14);
      sel = 3'd5;
      cycle();
      chk("sel5_valid1", {39'd0, ov1}, 40'd0);
      chk("sel5_ready1", {35'd0, rdy1}, 40'd0);

`ifdef STREAM_MUX_LOCK_EN
      // Channel 1 packet of three beats locks out channel 0
      do_reset();
      sel = 3'd1;
      in_valid = 5'b00001;
      beat0(0, 8'h10);
      in_valid = 5'b00011;
      in_last  = 5'b11101;
      beat0(1, 8'h11);
      chk("lk_last_a", {39'd0, ol0}, 40'd0);
      beat0(1, 8'h11);
      in_last  = 5'b11111;
      beat0(1, 8'h11);
      chk("lk_last_b", {39'd0, ol0}, 40'd1);
      beat0(0, 8'h10);
`endif

      // Randomized traffic
      for (int i = 0; i < 600; i++) begin
         in_valid  = 5'($urandom);
         in_data   = {8'($urandom), $urandom};
         in_last   = 5'($urandom) | 5'($urandom);
         sel       = 3'($urandom);
         out_ready = ($urandom_range(9) < 7);
         cycle();
      end

      // Reset while a beat is held discards it; channel 0 wins first afterwards
      in_data  = {8'h14, 8'h13, 8'h12, 8'h11, 8'h10};
      in_valid = 5'b11111;
      in_last  = 5'b11111;
      out_ready = 1'b0;
      cycle();
      do_reset();
      out_ready = 1'b1;
      beat0(0, 8'h10);
      beat0(1, 8'h11);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
